instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of control_unit. Holds the PC and issues word fetches to instruction memory.
//  Buffers returned words in a small in-order prefetch FIFO, then presents the head instruction with
//  pre-split fields (opcode/funct/rs/rt/rd/shamt/imm) to decode and control over a valid/ready handshake.
//  Branch/jump redirects flush the buffer and discard in-flight responses.
// PARAMETERS
//  XLEN       32   PC / instruction-memory address width
//  RESET_PC   0    PC value loaded at reset
//  FIFO_DEPTH 2    prefetch entries, power of 2, >=2; also the limit on outstanding requests
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     async active-low reset
//  imem_req_valid out  1     fetch request
//  imem_req_addr  out  XLEN  word address of request (= fetch_pc)
//  imem_req_ready in   1     memory accepts request this cycle
//  imem_rsp_valid in   1     response word valid; responses return in request order, latency >=1
//  imem_rsp_data  in   32    instruction word
//  redirect_valid in   1     taken branch/jump
//  redirect_pc    in   XLEN  new PC; bits [1:0] ignored and forced to 0
//  instr_valid    out  1     head instruction valid
//  instr_ready    in   1     decode consumes head this cycle
//  instr          out  32    head instruction word
//  instr_pc       out  XLEN  PC of head instruction
//  opcode         out  6     instr[31:26]
//  funct          out  6     instr[5:0]
//  rs, rt, rd     out  5 ea  instr[25:21], [20:16], [15:11]
//  shamt          out  5     instr[10:6]
//  imm            out  16    instr[15:0]
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0.
//   imem_req_valid=0 and instr_valid=0 while rst_n=0; all data outputs read 0.
//  Credit rule: imem_req_valid = (fifo_count + outstanding < FIFO_DEPTH). This guarantees every response
//   has a slot; no response backpressure exists.
//  Request handshake (valid & ready): fetch_pc += 4 (mod 2^XLEN, wraps 0xFFFFFFFC->0); outstanding++.
//   imem_req_addr may change before acceptance (no stability requirement).
//  Response: outstanding--. If drop_cnt>0, word discarded and drop_cnt--; else pushed with its PC.
//   Per-entry PC comes from a PC queue written at request acceptance.
//  Output: instr_valid = FIFO non-empty. Fields are pure slices of the head word.
//   Pop on instr_valid & instr_ready.
//  Latency: with 1-cycle memory and ready=1, first instr_valid is 2 cycles after reset release.
//   Steady state delivers one instruction per cycle.
//  Redirect (highest priority), same cycle:
//   - FIFO flushed; instr_valid=0 next cycle. A pop in the redirect cycle is still a legal consume.
//   - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//   - drop_cnt <= outstanding + (req handshake this cycle) - (rsp_valid this cycle).
//   - A response arriving in the redirect cycle is discarded.
//   - Requests resume next cycle, subject to the credit rule (dropped requests still hold credits).
//  Simultaneous push and pop on a full FIFO: legal, count unchanged.
//   Simultaneous rsp and req: outstanding unchanged.
//  Back-to-back redirects: each recomputes drop_cnt from the current outstanding; the last one wins.
//  Reset mid-operation: all state cleared immediately. Later stray responses must not occur (memory
//   reset together); behaviour if they do is undefined.
// STRUCTURE
//  Shared package rv_pkg: XLEN, INSTR_W=32, field bit positions (OPC/RS/RT/RD/SHAMT/FUNCT/IMM),
//   PC_STEP=4, NOP encoding 32'h0.
//  One sub-module: fetch_fifo (sync FIFO, width 32+XLEN, depth FIFO_DEPTH, flush input, count output).
//  PC register, outstanding/drop counters and credit logic live in instr_fetch_unit.
// TESTING
//  1 Reset release, mem 1-cycle, ready=1 -> addresses 0,4,8,... each cycle;
//    instr_valid at cycle 2; instr_pc tracks addresses.
//  2 Word 32'h014B4820 (add) -> opcode=0, funct=6'h20, rs=10, rt=11, rd=9, shamt=0.
//    Word 32'h01095024 -> funct=6'h24.
//  3 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued, then req_valid=0.
//    Ready=1 -> in-order drain, no loss or duplication.
//  4 Mem latency 3, redirect to 0x103 with 2 outstanding -> both stale responses dropped.
//    Next request addr=0x100; first delivered instr_pc=0x100.
//  5 fetch_pc=0xFFFFFFFC accepted -> next addr 0x00000000. Redirect together with a pop and a response
//    in the same cycle -> popped instr counted once; response dropped.
//  6 Assert rst_n=0 mid-burst -> req_valid and instr_valid fall immediately;
//    after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch/decode definitions: widths, instruction field positions and a field splitter.
package rv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] w);
        instr_fields_t f;
        f.opcode = w[OPC_HI:OPC_LO];
        f.funct  = w[FUNCT_HI:FUNCT_LO];
        f.rs     = w[RS_HI:RS_LO];
        f.rt     = w[RT_HI:RT_LO];
        f.rd     = w[RD_HI:RD_LO];
        f.shamt  = w[SHAMT_HI:SHAMT_LO];
        f.imm    = w[IMM_HI:IMM_LO];
        return f;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer with single-cycle flush; head entry is readable combinationally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A push into a full buffer only lands when the head leaves in the same cycle.
        do_push  = push && !flush && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited word fetches, in-order prefetch buffer, redirect flush with
// discard of responses that were already in flight.
module instr_fetch_unit #(
    parameter int              XLEN       = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [5:0]      opcode,
    output logic [5:0]      funct,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [15:0]     imm
);

    localparam int INSTR_W = rv_pkg::INSTR_W;
    localparam int ENTRY_W = INSTR_W + XLEN;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0]   pcq_wr_q, pcq_wr_d;
    logic [PTR_W-1:0]   pcq_rd_q, pcq_rd_d;
    logic [XLEN-1:0]    pcq_mem_q [FIFO_DEPTH];

    logic               req_fire;
    logic               rsp_drop;
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_push_data;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credit_used;
    logic               redirect_lsb_unused;
    rv_pkg::instr_fields_t fields;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Dropped requests keep their credit until their response returns.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req_valid = rst_n && (credit_used < CREDIT_MAX);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop       = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
    assign fifo_push      = imem_rsp_valid && !rsp_drop;
    assign fifo_push_data = {pcq_mem_q[pcq_rd_q], imem_rsp_data};
    assign fifo_pop       = instr_valid && instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;

        // The PC queue tracks every outstanding request, dropped or not.
        if (req_fire) begin
            pcq_wr_d = pcq_wr_q + PTR_W'(1);
        end
        if (imem_rsp_valid) begin
            pcq_rd_d = pcq_rd_q + PTR_W'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(rv_pkg::PC_STEP);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outputs read as NOP/zero whenever nothing valid is held, including during reset.
    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? fifo_head[INSTR_W-1:0] : rv_pkg::NOP;
    assign instr_pc    = instr_valid ? fifo_head[ENTRY_W-1:INSTR_W] : '0;
    assign fields      = rv_pkg::split_instr(instr);

    assign opcode = fields.opcode;
    assign funct  = fields.funct;
    assign rs     = fields.rs;
    assign rt     = fields.rt;
    assign rd     = fields.rd;
    assign shamt  = fields.shamt;
    assign imm    = fields.imm;

endmodule
